// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen: Fibonacci-LFSR PRBS source emitting OUT_W bits per beat on a valid/ready stream.
// Optional error injection input err_inj is enabled by defining LFSR_ERR_INJ_EN.
module lfsr_prbs_gen #(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10010,
  parameter logic [WIDTH-1:0] SEED  = 5'b11111,
  parameter int unsigned      OUT_W = 1
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_seed,
`ifdef LFSR_ERR_INJ_EN
  input  logic             err_inj,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_wrap,
  output logic             lockup
);
  localparam logic [32:0] P = (33'd1 << WIDTH) - 33'd1;
  logic [WIDTH-1:0] state_q, state_d, pos_q, pos_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, wrap_q, wrap_d, lockup_q, gen;
  logic [32:0]      pos_sum;
  // Unroll OUT_W steps; the first (oldest) bit lands in the MSB.
  always_comb begin
    state_d = state_q;
    data_d  = '0;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      data_d[i] = state_d[WIDTH-1];
      state_d   = {state_d[WIDTH-2:0], ^(state_d & TAPS)};
    end
`ifdef LFSR_ERR_INJ_EN
    data_d[OUT_W-1] = data_d[OUT_W-1] ^ err_inj;
`endif
  end
  assign pos_sum = 33'(pos_q) + 33'(OUT_W);
  assign pos_d   = WIDTH'(pos_sum % P);
  assign wrap_d  = (pos_q == '0) || (pos_sum > P);
  assign gen     = en && (!valid_q || out_ready) && !load;
  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state_q  <= SEED;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else if (load) begin
      state_q  <= (load_seed == '0) ? SEED : load_seed;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      lockup_q <= (load_seed == '0);
    end else begin
      lockup_q <= 1'b0;
      if (gen) begin
        state_q <= state_d;
        pos_q   <= pos_d;
        data_q  <= data_d;
        wrap_q  <= wrap_d;
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_wrap  = wrap_q;
  assign lockup    = lockup_q;
endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb_lfsr_prbs_gen: scoreboard bench driving a 1-bit and a 4-bit instance with shared stimulus.
// Reference sequence is built from the recurrence b[n+5] = b[n] ^ b[n+3] (taps 10010).
module tb_lfsr_prbs_gen;
  typedef struct packed {logic [3:0] d; logic w;} beat_t;
  logic clk = 1'b0, preset = 1'b0, en = 1'b0, load = 1'b0, out_ready = 1'b0;
  logic [4:0] load_seed = 5'd0;
  logic       out_valid_a, out_wrap_a, lockup_a, out_data_a;
  logic       out_valid_b, out_wrap_b, lockup_b;
  logic [3:0] out_data_b;
`ifdef LFSR_ERR_INJ_EN
  logic err_inj = 1'b0;
`endif
  int nvec = 0, nerr = 0;
  bit seq[31];
  beat_t qa[$], qb[$];
  int k = 0;
  logic mvalid = 0, mvalid_nx = 0, mlock = 0, mlock_nx = 0;
  int first_cnt = 0;
  logic [9:0] first_bits = '0;

  lfsr_prbs_gen u_a (
    .clk(clk), .preset(preset), .en(en), .load(load), .load_seed(load_seed),
`ifdef LFSR_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_wrap(out_wrap_a), .lockup(lockup_a));

  lfsr_prbs_gen #(.OUT_W(4)) u_b (
    .clk(clk), .preset(preset), .en(en), .load(load), .load_seed(load_seed),
`ifdef LFSR_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_wrap(out_wrap_b), .lockup(lockup_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(input logic [4:0] s);
    for (int n = 0; n < 31; n++) seq[n] = (n < 5) ? s[4-n] : (seq[n-5] ^ seq[n-2]);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    k = 0;
    build(5'b11111);
    mvalid = 0; mvalid_nx = 0; mlock = 0; mlock_nx = 0;
  endtask

  // One cycle of stimulus, called at posedge+2; predicts what the next edge does.
  task automatic step(input logic e, input logic r, input logic l, input logic [4:0] s, input logic inj);
    beat_t ba, bb;
    int pa, pb;
    mvalid = mvalid_nx;
    mlock  = mlock_nx;
    en = e; out_ready = r; load = l; load_seed = s;
`ifdef LFSR_ERR_INJ_EN
    err_inj = inj;
`endif
    if (l) begin
      qa.delete();
      qb.delete();
      k = 0;
      build(s == 5'd0 ? 5'b11111 : s);
      mvalid_nx = 0;
      mlock_nx  = (s == 5'd0);
    end else begin
      mlock_nx = 0;
      if (e && (!mvalid || r)) begin
        pa = k % 31;
        pb = (4 * k) % 31;
        ba.d = {3'b000, seq[pa]};
        ba.w = (pa == 0);
        for (int j = 0; j < 4; j++) bb.d[3-j] = seq[(pb + j) % 31];
        bb.w = (pb == 0) || (pb + 4 > 31);
`ifdef LFSR_ERR_INJ_EN
        ba.d[0] = ba.d[0] ^ inj;
        bb.d[3] = bb.d[3] ^ inj;
`endif
        qa.push_back(ba);
        qb.push_back(bb);
        k++;
        mvalid_nx = 1;
      end else if (r) begin
        mvalid_nx = 0;
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares presented beats against queue heads, pops on accept.
  always @(negedge clk) begin
    chk("valid_a", 32'(out_valid_a), 32'(mvalid));
    chk("valid_b", 32'(out_valid_b), 32'(mvalid));
    chk("lockup_a", 32'(lockup_a), 32'(mlock));
    chk("lockup_b", 32'(lockup_b), 32'(mlock));
    if (out_valid_a && !load) begin
      if (qa.size() == 0) chk("beat_a_expected", 32'(out_valid_a), 32'd0);
      else begin
        chk("data_a", 32'(out_data_a), 32'(qa[0].d[0]));
        chk("wrap_a", 32'(out_wrap_a), 32'(qa[0].w));
        if (out_ready) begin
          if (first_cnt < 10) begin
            first_bits = {first_bits[8:0], out_data_a};
            first_cnt++;
            if (first_cnt == 10) chk("first10_a", 32'(first_bits), 32'h3E6);
          end
          void'(qa.pop_front());
        end
      end
    end
    if (out_valid_b && !load) begin
      if (qb.size() == 0) chk("beat_b_expected", 32'(out_valid_b), 32'd0);
      else begin
        chk("data_b", 32'(out_data_b), 32'(qb[0].d));
        chk("wrap_b", 32'(out_wrap_b), 32'(qb[0].w));
        if (out_ready) void'(qb.pop_front());
      end
    end
  end

  initial begin
    logic [4:0] s;
    model_reset();
    #1;
    chk("rst_data_a", 32'(out_data_a), 32'd0);
    chk("rst_data_b", 32'(out_data_b), 32'd0);
    chk("rst_wrap_b", 32'(out_wrap_b), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    preset = 1'b1;
    // Free-running stream past two period wraps.
    repeat (70) step(1, 1, 0, 5'd0, 0);
    // Backpressure for 5 cycles mid-stream, then resume.
    repeat (5) step(1, 0, 0, 5'd0, 0);
    repeat (10) step(1, 1, 0, 5'd0, 0);
    // Zero-seed reload: lockup pulse and restart from SEED.
    step(0, 1, 1, 5'd0, 0);
    repeat (12) step(1, 1, 0, 5'd0, 0);
    // Single injected beat (only meaningful when the feature is built in).
    step(1, 1, 0, 5'd0, 1);
    repeat (6) step(1, 1, 0, 5'd0, 0);
    // Randomised traffic with occasional reloads.
    repeat (500) begin
      s = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(19) == 0, s,
           $urandom_range(7) == 0);
    end
    // Load together with en, then async reset mid-beat.
    step(1, 1, 1, 5'b10101, 0);
    step(1, 1, 0, 5'd0, 0);
    step(1, 0, 0, 5'd0, 0);
    en = 1'b0; load = 1'b0; out_ready = 1'b0;
    #2 preset = 1'b0;
    #1;
    chk("async_valid_a", 32'(out_valid_a), 32'd0);
    chk("async_valid_b", 32'(out_valid_b), 32'd0);
    chk("async_data_b", 32'(out_data_b), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    preset = 1'b1;
    repeat (40) step(1, 1, 0, 5'd0, 0);
    repeat (4) step(0, 1, 0, 5'd0, 0);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
